// File: rtl/usb_rx_bit_decoder_if.sv
// Line and decoded-bit signals between the USB full-speed receive front end
// and its neighbours: raw D+/D- in, bit/strobe/status out.
interface usb_rx_bit_decoder_if;
  logic d_plus_in;
  logic d_minus_in;
  logic bit_out;
  logic shift_enable;
  logic stuff_skip;
  logic sync_rst;
  logic crc_rcv;
  logic eop;
  logic rx_active;
  logic rx_error;

  modport master (
    output d_plus_in, d_minus_in,
    input  bit_out, shift_enable, stuff_skip, sync_rst, crc_rcv, eop, rx_active, rx_error
  );

  modport slave (
    input  d_plus_in, d_minus_in,
    output bit_out, shift_enable, stuff_skip, sync_rst, crc_rcv, eop, rx_active, rx_error
  );
endinterface

// File: rtl/usb_rx_bit_decoder.sv
// USB full-speed receive front end: line sync, bit-clock recovery, NRZI decode,
// unstuffing, SYNC/EOP detection. Define USB_RX_STUFF_CHECK_EN to flag seven 1s.
module usb_rx_bit_decoder #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_POINT = 3
) (
  input  logic clk,
  input  logic n_rst,
  usb_rx_bit_decoder_if.slave bus
);
  localparam int PW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {IDLE, SYNC, RECEIVE, EOP_WAIT, ERROR} state_t;

  logic          dp_p0, dp_p1, dm_p0, dm_p1, dp_last;
  logic [PW-1:0] phase;
  logic          edge_det, strobe, prev_dp;
  logic          se0, j_line, bit_dec;
  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d, ones_q, ones_d;
  logic          bit_q, bit_d, shift_q, shift_d, skip_q, skip_d, srst_q, srst_d;
  logic          crc_q, eop_q, act_q, err_q;

  // Stage p0/p1: two-flop synchronizer, idle line is J
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dp_p0   <= 1'b1;
      dp_p1   <= 1'b1;
      dm_p0   <= 1'b0;
      dm_p1   <= 1'b0;
      dp_last <= 1'b1;
    end else begin
      dp_p0   <= bus.d_plus_in;
      dp_p1   <= dp_p0;
      dm_p0   <= bus.d_minus_in;
      dm_p1   <= dm_p0;
      dp_last <= dp_p1;
    end
  end

  assign edge_det = dp_p1 ^ dp_last;
  // The resync cycle never samples, so the first edge out of IDLE cannot corrupt prev_dp
  assign strobe   = (phase == PW'(SAMPLE_POINT)) && !edge_det;
  assign se0      = !dp_p1 && !dm_p1;
  assign j_line   = dp_p1 && !dm_p1;
  assign bit_dec  = (dp_p1 == prev_dp);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      phase   <= '0;
      prev_dp <= 1'b1;
    end else begin
      if (edge_det || phase == PW'(CLKS_PER_BIT - 1)) phase <= '0;
      else                                              phase <= phase + PW'(1);
      if (strobe) prev_dp <= dp_p1;
    end
  end

  // cnt_q is reused per state: SYNC zeros, EOP_WAIT SE0s, ERROR consecutive Js
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ones_d  = ones_q;
    bit_d   = bit_q;
    shift_d = 1'b0;
    skip_d  = 1'b0;
    srst_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (edge_det) begin
          state_d = SYNC;
          cnt_d   = 3'd0;
        end
      end
      SYNC: begin
        if (strobe) begin
          if (se0) begin
            state_d = ERROR;
            cnt_d   = 3'd0;
          end else if (!bit_dec) begin
            if (cnt_q != 3'd7) cnt_d = cnt_q + 3'd1;
          end else if (cnt_q == 3'd7) begin
            state_d = RECEIVE;
            srst_d  = 1'b1;
            ones_d  = 3'd1;
          end else begin
            state_d = ERROR;
            cnt_d   = 3'd0;
          end
        end
      end
      RECEIVE: begin
        if (strobe) begin
          if (se0) begin
            state_d = EOP_WAIT;
            cnt_d   = 3'd1;
          end else if (ones_q == 3'd6) begin
            ones_d = 3'd0;
`ifdef USB_RX_STUFF_CHECK_EN
            if (bit_dec) begin
              state_d = ERROR;
              cnt_d   = 3'd0;
            end else begin
              skip_d = 1'b1;
            end
`else
            skip_d = 1'b1;
`endif
          end else begin
            shift_d = 1'b1;
            bit_d   = bit_dec;
            ones_d  = bit_dec ? ones_q + 3'd1 : 3'd0;
          end
        end
      end
      EOP_WAIT: begin
        if (strobe) begin
          if (se0) begin
            if (cnt_q == 3'd2) begin
              state_d = ERROR;
              cnt_d   = 3'd0;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end else if (j_line) begin
            state_d = IDLE;
          end else begin
            state_d = ERROR;
            cnt_d   = 3'd0;
          end
        end
      end
      ERROR: begin
        if (strobe) begin
          if (!j_line)             cnt_d   = 3'd0;
          else if (cnt_q == 3'd6)  state_d = IDLE;
          else                     cnt_d   = cnt_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage p2: state and registered outputs
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      ones_q  <= 3'd0;
      bit_q   <= 1'b0;
      shift_q <= 1'b0;
      skip_q  <= 1'b0;
      srst_q  <= 1'b0;
      crc_q   <= 1'b0;
      eop_q   <= 1'b0;
      act_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ones_q  <= ones_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      skip_q  <= skip_d;
      srst_q  <= srst_d;
      crc_q   <= (state_d == RECEIVE);
      eop_q   <= (state_d == EOP_WAIT);
      act_q   <= (state_d == SYNC) || (state_d == RECEIVE) || (state_d == EOP_WAIT);
      err_q   <= (state_d == ERROR);
    end
  end

  assign bus.bit_out      = bit_q;
  assign bus.shift_enable = shift_q;
  assign bus.stuff_skip   = skip_q;
  assign bus.sync_rst     = srst_q;
  assign bus.crc_rcv      = crc_q;
  assign bus.eop          = eop_q;
  assign bus.rx_active    = act_q;
  assign bus.rx_error     = err_q;
endmodule
